// File: rtl/mlaccel_sequencer.sv
// mlaccel_sequencer: fetches a program into a prefetch FIFO and issues it to the compute block
module mlaccel_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [16:0] start_pc,
    input  logic [15:0] start_len,
    output logic        done,
    output logic        busy,
    output logic        mem_ren,
    input  logic        mem_grant,
    output logic [15:0] mem_addr,
    input  logic [63:0] mem_rdata,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_insn,
    input  logic        compute_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [31:0]   fifo [FIFO_DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [AW:0]   cnt;
    logic [15:0]   rem, waddr;
    logic          skip, rvalid, issued, fire, pop, head_sync, head_ret, grab;
    logic [1:0]    avail, npush;
    logic [31:0]   lo_insn;

    // head decode: forward compute opcodes, retire Sync once compute is idle, spot Return
    always_comb begin
        cmd_insn  = fifo[rptr];
        head_sync = cnt != '0 && cmd_insn[5:0] == 6'd0;
        head_ret  = cnt != '0 && cmd_insn[5:0] == 6'd1;
        cmd_valid = cnt != '0 && cmd_insn[5:0] > 6'd1;
        fire      = cmd_valid && cmd_ready;
        pop       = fire || (head_sync && !compute_busy && !issued);
    end

    // fetch: halves kept from the returning word, and a read only when its data is guaranteed room
    always_comb begin
        avail    = skip ? 2'd1 : 2'd2;
        npush    = (state != RUN || !rvalid || head_ret) ? 2'd0 : (rem < 16'(avail) ? rem[1:0] : avail);
        lo_insn  = skip ? mem_rdata[63:32] : mem_rdata[31:0];
        mem_ren  = state == RUN && !head_ret && rem > 16'(npush) && int'(cnt) + (rvalid ? 4 : 2) <= FIFO_DEPTH;
        mem_addr = waddr;
        grab     = mem_ren && mem_grant;
    end

    // control: run/drain sequencing and host status
    always_comb begin
        state_next  = state;
        start_ready = state == IDLE;
        busy        = state != IDLE;
        done        = state == DRAIN && !compute_busy && !issued;
        if (start_ready && start_valid) state_next = start_len == 16'd0 ? DRAIN : RUN;
        if (state == RUN && (head_ret || (rem == 16'd0 && !rvalid && cnt == '0))) state_next = DRAIN;
        if (done) state_next = IDLE;
    end

    // state, FIFO pointers and fetch bookkeeping; Return flushes everything still buffered
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            rptr   <= '0;
            wptr   <= '0;
            cnt    <= '0;
            rem    <= '0;
            waddr  <= '0;
            skip   <= 1'b0;
            rvalid <= 1'b0;
            issued <= 1'b0;
        end else begin
            state  <= state_next;
            rvalid <= grab;
            issued <= fire;
            if (start_ready && start_valid) begin
                waddr <= start_pc[16:1];
                skip  <= start_pc[0];
                rem   <= start_len;
            end else begin
                waddr <= waddr + 16'(grab);
                skip  <= skip && !rvalid;
                rem   <= head_ret ? '0 : rem - 16'(npush);
            end
            rptr <= head_ret ? '0 : rptr + AW'(pop);
            wptr <= head_ret ? '0 : wptr + AW'(npush);
            cnt  <= head_ret ? '0 : cnt + (AW+1)'(npush) - (AW+1)'(pop);
        end
    end

    // prefetch storage: up to two instructions written per returning word
    always_ff @(posedge clock) begin
        if (npush != 2'd0) fifo[wptr] <= lo_insn;
        if (npush == 2'd2) fifo[wptr + AW'(1)] <= mem_rdata[63:32];
    end
endmodule

// File: tb/tb_mlaccel_sequencer.sv
// tb_mlaccel_sequencer: randomized scoreboard bench for the program sequencer
module tb_mlaccel_sequencer;
    logic        clock = 0;
    logic        reset = 1;
    logic        start_valid = 0;
    logic        start_ready;
    logic [16:0] start_pc = 0;
    logic [15:0] start_len = 0;
    logic        done, busy, mem_ren;
    logic        mem_grant = 0;
    logic [15:0] mem_addr;
    logic [63:0] mem_rdata = 0;
    logic        cmd_valid;
    logic        cmd_ready = 0;
    logic [31:0] cmd_insn;
    logic        compute_busy = 0;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int ready_pct = 100, grant_pct = 100, busy_lat = -1;
    int n_reads = 0, n_issued = 0, done_cnt = 0;
    int first_issue = -1, last_issue = -1, last_fall = -1;
    int watch_cyc = -1, watch_fall = -1;
    logic [31:0] watch_insn = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ovr[int];

    mlaccel_sequencer #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_pc(start_pc), .start_len(start_len),
        .done(done), .busy(busy),
        .mem_ren(mem_ren), .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_insn(cmd_insn),
        .compute_busy(compute_busy)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // program image: explicit overrides, otherwise a pc-derived compute instruction
    function automatic logic [31:0] insn_at(input int p);
        int q;
        q = p & 'h1FFFF;
        if (ovr.exists(q)) return ovr[q];
        return {q[16:0] ^ 17'h0A5A5, 9'(q * 7), 6'(2 + q % 62)};
    endfunction

    function automatic logic [63:0] word_at(input logic [15:0] a);
        int p;
        p = 2 * int'(a);
        return {insn_at(p + 1), insn_at(p)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill_random(input int pc, input int len);
        for (int i = 0; i < len; i++) begin
            logic [31:0] w;
            int r;
            w = $urandom;
            r = int'($urandom_range(99));
            w[5:0] = r < 10 ? 6'd0 : r < 13 ? 6'd1 : 6'(2 + $urandom_range(61));
            ovr[(pc + i) & 'h1FFFF] = w;
        end
    endtask

    // reference: program order, Sync dropped, Return ends the program
    task automatic start_prog(input int pc, input int len, output int n);
        int t;
        t = 0;
        for (int i = 0; i < len; i++) begin
            logic [31:0] w;
            w = insn_at(pc + i);
            if (w[5:0] == 6'd1) break;
            if (w[5:0] != 6'd0) exp_q.push_back(w);
        end
        while (!start_ready && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("start_ready_before_start", 64'(start_ready), 64'(1));
        start_pc = 17'(pc);
        start_len = 16'(len);
        start_valid = 1;
        n = cyc;
        first_issue = -1;
        n_reads = 0;
        @(posedge clock);
        #1;
        start_valid = 0;
    endtask

    task automatic wait_done(input string name);
        int d0, t;
        d0 = done_cnt;
        t = 0;
        while (done_cnt == d0 && t < 2000) begin
            @(posedge clock);
            #1;
            t++;
        end
        repeat (3) @(posedge clock);
        #1;
        check({name, "_done_once"}, 64'(done_cnt - d0), 64'(1));
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // memory: random grant, data for an accepted read presented in the following cycle
    initial begin
        logic acc;
        logic [15:0] a;
        forever begin
            @(negedge clock);
            acc = mem_ren && mem_grant;
            a = mem_addr;
            if (acc) n_reads++;
            @(posedge clock);
            #2;
            mem_rdata = acc ? word_at(a) : {$urandom, $urandom};
            mem_grant = $urandom_range(99) < grant_pct;
        end
    end

    initial forever begin
        @(posedge clock);
        #2;
        cmd_ready = $urandom_range(99) < ready_pct;
    end

    // compute pipeline: busy rises the cycle after an accepted instruction
    initial begin
        logic f;
        int b;
        b = 0;
        forever begin
            @(negedge clock);
            f = cmd_valid && cmd_ready && !reset;
            @(posedge clock);
            #1;
            if (f) b = busy_lat < 0 ? int'($urandom_range(4)) : busy_lat;
            else if (b > 0) b--;
            compute_busy = b != 0;
        end
    end

    // monitor: scoreboard pops on every accepted instruction, plus handshake and done checks
    initial begin
        logic prev_stall, cb_prev;
        logic [31:0] prev_insn, e;
        prev_stall = 0;
        cb_prev = 0;
        prev_insn = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 0;
                cb_prev = compute_busy;
            end else begin
                if (cb_prev && !compute_busy) last_fall = cyc;
                cb_prev = compute_busy;
                if (prev_stall) begin
                    check("stall_valid_held", 64'(cmd_valid), 64'(1));
                    check("stall_insn_stable", 64'(cmd_insn), 64'(prev_insn));
                end
                if (cmd_valid && cmd_ready) begin
                    n_issued++;
                    if (first_issue < 0) first_issue = cyc;
                    last_issue = cyc;
                    if (cmd_insn == watch_insn) begin
                        watch_cyc = cyc;
                        watch_fall = last_fall;
                    end
                    check("no_local_opcode", 64'(cmd_insn[5:0] > 6'd1), 64'(1));
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_issue: got %0h expected nothing (cycle %0d)", cmd_insn, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue", 64'(cmd_insn), 64'(e));
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_compute_idle", 64'(compute_busy), 64'(0));
                    check("done_all_issued", 64'(exp_q.size()), 64'(0));
                end
                prev_stall = cmd_valid && !cmd_ready;
                prev_insn = cmd_insn;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int n, t, base, d0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_start_ready", 64'(start_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_mem_ren", 64'(mem_ren), 64'(0));
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        reset = 0;
        @(posedge clock);
        #1;

        start_prog(0, 4, n);
        wait_done("basic");
        check("basic_first_issue_cycle", 64'(first_issue), 64'(n + 3));
        check("basic_last_issue_cycle", 64'(last_issue), 64'(n + 6));

        start_prog(3, 2, n);
        wait_done("odd");
        check("odd_read_count", 64'(n_reads), 64'(2));

        base = n_issued;
        start_prog(300, 40, n);
        t = 0;
        while (n_issued - base < 5 && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        ready_pct = 0;
        repeat (10) @(posedge clock);
        #1;
        check("bp_mem_ren_stopped", 64'(mem_ren), 64'(0));
        check("bp_valid_held", 64'(cmd_valid), 64'(1));
        ready_pct = 100;
        wait_done("bp");

        ovr[101] = {26'h3, 6'd0};
        busy_lat = 5;
        watch_insn = insn_at(102);
        start_prog(100, 4, n);
        wait_done("sync");
        check("sync_release_cycle", 64'(watch_cyc), 64'(watch_fall + 1));
        busy_lat = -1;
        ovr.delete();

        ovr[202] = {26'h1234, 6'd1};
        base = n_issued;
        start_prog(200, 8, n);
        wait_done("ret");
        check("ret_issue_count", 64'(n_issued - base), 64'(2));
        ovr.delete();
        start_prog(400, 5, n);
        wait_done("after_ret");

        ready_pct = 0;
        start_prog(500, 60, n);
        t = 0;
        while (n_reads < 2 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        d0 = done_cnt;
        reset = 1;
        @(posedge clock);
        #1;
        check("rstmid_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rstmid_mem_ren", 64'(mem_ren), 64'(0));
        check("rstmid_start_ready", 64'(start_ready), 64'(1));
        check("rstmid_busy", 64'(busy), 64'(0));
        reset = 0;
        exp_q.delete();
        ready_pct = 100;
        repeat (3) @(posedge clock);
        #1;
        check("rstmid_no_done", 64'(done_cnt - d0), 64'(0));
        check("rstmid_still_idle", 64'(cmd_valid), 64'(0));
        start_prog(600, 6, n);
        wait_done("after_rst");

        start_prog(50, 0, n);
        wait_done("len0");

        start_prog(17'h1FFFD, 7, n);
        wait_done("wrap");

        for (int k = 0; k < 12; k++) begin
            int pc, len;
            ovr.delete();
            pc = int'($urandom_range(17'h1FFFF));
            len = int'($urandom_range(24));
            fill_random(pc, len);
            ready_pct = int'($urandom_range(30, 100));
            grant_pct = int'($urandom_range(30, 100));
            start_prog(pc, len, n);
            wait_done("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
